// File: rtl/instr_decode_pkg.sv
// Shared decode definitions: opcode/funct/ALU-op constants, the decoded-instruction
// struct and the register-read helper used by the load-use interlock.
package instr_decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;

    typedef struct packed {
        logic [5:0]  Op;
        logic [4:0]  Rs;
        logic [4:0]  Rt;
        logic [4:0]  Rd;
        logic [15:0] imm;
        logic [25:0] addr;
        logic [2:0]  alu_src;
        logic        alu_control;
        logic        jump;
        logic        jumpLink;
        logic        jumpReg;
        logic        branchE;
        logic        branchNE;
        logic        mem_write;
        logic        reg_write;
        logic        regDst;
        logic        memToReg;
        logic        illegal;
    } decoded_t;

    // j/jal read no register; Rt is a source only for R-type, branches and stores.
    function automatic logic reads_reg(input logic [31:0] instr, input logic [4:0] r);
        logic [5:0] op;
        logic       rs_used;
        logic       rt_used;
        op      = instr[31:26];
        rs_used = (op != OP_J) && (op != OP_JAL);
        rt_used = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        return (r != 5'd0) &&
               ((rs_used && (instr[25:21] == r)) || (rt_used && (instr[20:16] == r)));
    endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational MIPS decoder: one 32-bit instruction word in, decoded_t out.
module instr_decode_comb
    import instr_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    // Raw field extraction plus control decode; unknown encodings raise illegal only.
    always_comb begin
        dec_o      = '0;
        dec_o.Op   = instr_i[31:26];
        dec_o.Rs   = instr_i[25:21];
        dec_o.Rt   = instr_i[20:16];
        dec_o.Rd   = instr_i[15:11];
        dec_o.imm  = instr_i[15:0];
        dec_o.addr = instr_i[25:0];
        case (instr_i[31:26])
            OP_RTYPE: begin
                case (instr_i[5:0])
                    FN_ADD: begin
                        dec_o.reg_write = 1'b1;
                        dec_o.regDst    = 1'b1;
                        dec_o.alu_src   = ALU_ADD;
                    end
                    FN_SUB: begin
                        dec_o.reg_write = 1'b1;
                        dec_o.regDst    = 1'b1;
                        dec_o.alu_src   = ALU_SUB;
                    end
                    FN_XOR: begin
                        dec_o.reg_write = 1'b1;
                        dec_o.regDst    = 1'b1;
                        dec_o.alu_src   = ALU_XOR;
                    end
                    FN_SLT: begin
                        dec_o.reg_write = 1'b1;
                        dec_o.regDst    = 1'b1;
                        dec_o.alu_src   = ALU_SLT;
                    end
                    FN_JR:   dec_o.jumpReg = 1'b1;
                    default: dec_o.illegal = 1'b1;
                endcase
            end
            OP_J:   dec_o.jump = 1'b1;
            OP_JAL: begin
                dec_o.jump      = 1'b1;
                dec_o.jumpLink  = 1'b1;
                dec_o.reg_write = 1'b1;
            end
            OP_BEQ: begin
                dec_o.branchE = 1'b1;
                dec_o.alu_src = ALU_SUB;
            end
            OP_BNE: begin
                dec_o.branchNE = 1'b1;
                dec_o.alu_src  = ALU_SUB;
            end
            OP_ADDI: begin
                dec_o.reg_write   = 1'b1;
                dec_o.alu_control = 1'b1;
                dec_o.alu_src     = ALU_ADD;
            end
            OP_XORI: begin
                dec_o.reg_write   = 1'b1;
                dec_o.alu_control = 1'b1;
                dec_o.alu_src     = ALU_XOR;
            end
            OP_LW: begin
                dec_o.reg_write   = 1'b1;
                dec_o.memToReg    = 1'b1;
                dec_o.alu_control = 1'b1;
            end
            OP_SW: begin
                dec_o.mem_write   = 1'b1;
                dec_o.alu_control = 1'b1;
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_decode_queue.sv
// Instruction FIFO feeding a registered decode stage with valid/ready on both sides.
// Optional load-use interlock enabled by defining INSTR_DECODE_HAZARD_EN.
module instruction_decode_queue
    import instr_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [PC_W-1:0]              in_pc,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_W-1:0]              out_pc,
    output logic [5:0]                   Op,
    output logic [4:0]                   Rs,
    output logic [4:0]                   Rt,
    output logic [4:0]                   Rd,
    output logic [15:0]                  imm,
    output logic [25:0]                  addr,
    output logic [2:0]                   alu_src,
    output logic                         alu_control,
    output logic                         jump,
    output logic                         jumpLink,
    output logic                         jumpReg,
    output logic                         branchE,
    output logic                         branchNE,
    output logic                         mem_write,
    output logic                         reg_write,
    output logic                         regDst,
    output logic                         memToReg,
    output logic                         illegal,
    output logic                         hazard_stall,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [31:0]      instr_mem_q [DEPTH];
    logic [PC_W-1:0]  pc_mem_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    decoded_t         out_q, out_d;
    logic [PC_W-1:0]  out_pc_q, out_pc_d;
    logic             out_valid_q, out_valid_d;

    logic [31:0]      head_instr_s;
    logic [PC_W-1:0]  head_pc_s;
    decoded_t         head_dec_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             handoff_s;
    logic             can_load_s;
    logic             stall_s;

    assign head_instr_s = instr_mem_q[rd_ptr_q];
    assign head_pc_s    = pc_mem_q[rd_ptr_q];
    // A full queue refuses even when the head pops this cycle: no pass-through.
    assign in_ready_s   = !reset && (count_q != CNT_FULL);
    assign push_s       = in_valid && in_ready_s && !flush;
    assign handoff_s    = out_valid_q && out_ready;
    assign can_load_s   = (count_q != {CNT_W{1'b0}}) && (!out_valid_q || out_ready) && !flush;
    assign pop_s        = can_load_s && !stall_s;

    instr_decode_comb u_decode (
        .instr_i (head_instr_s),
        .dec_o   (head_dec_s)
    );

`ifdef INSTR_DECODE_HAZARD_EN
    logic       rec_v_q;
    logic [4:0] rec_r_q;
    logic       hazard_stall_q;
    logic       eff_v_s;
    logic [4:0] eff_r_s;

    // The lw leaving this cycle counts as the most recent hand-off for the head check.
    always_comb begin
        eff_v_s = rec_v_q;
        eff_r_s = rec_r_q;
        if (handoff_s) begin
            eff_v_s = (out_q.Op == OP_LW) && (out_q.Rt != 5'd0);
            eff_r_s = out_q.Rt;
        end else begin
            eff_v_s = rec_v_q;
            eff_r_s = rec_r_q;
        end
        stall_s = can_load_s && eff_v_s && reads_reg(head_instr_s, eff_r_s);
    end

    // Load record; a bubble consumes it so exactly one stall cycle is inserted.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rec_v_q        <= 1'b0;
            rec_r_q        <= 5'd0;
            hazard_stall_q <= 1'b0;
        end else if (stall_s) begin
            rec_v_q        <= 1'b0;
            hazard_stall_q <= 1'b1;
        end else begin
            rec_v_q        <= eff_v_s;
            rec_r_q        <= eff_r_s;
            hazard_stall_q <= 1'b0;
        end
    end

    assign hazard_stall = hazard_stall_q;
`else
    assign stall_s      = 1'b0;
    assign hazard_stall = 1'b0;
`endif

    // Next-state for pointers, occupancy and the output register; flush wins over all.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_d       = out_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            wr_ptr_d    = {PTR_W{1'b0}};
            rd_ptr_d    = {PTR_W{1'b0}};
            count_d     = {CNT_W{1'b0}};
            out_valid_d = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
            if (pop_s) begin
                out_d       = head_dec_s;
                out_pc_d    = head_pc_s;
                out_valid_d = 1'b1;
            end else if (handoff_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // Control and output-stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            out_q       <= '0;
            out_pc_q    <= {PC_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Entry storage is left unreset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign count       = count_q;
    assign Op          = out_q.Op;
    assign Rs          = out_q.Rs;
    assign Rt          = out_q.Rt;
    assign Rd          = out_q.Rd;
    assign imm         = out_q.imm;
    assign addr        = out_q.addr;
    assign alu_src     = out_q.alu_src;
    assign alu_control = out_q.alu_control;
    assign jump        = out_q.jump;
    assign jumpLink    = out_q.jumpLink;
    assign jumpReg     = out_q.jumpReg;
    assign branchE     = out_q.branchE;
    assign branchNE    = out_q.branchNE;
    assign mem_write   = out_q.mem_write;
    assign reg_write   = out_q.reg_write;
    assign regDst      = out_q.regDst;
    assign memToReg    = out_q.memToReg;
    assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Directed plus randomized bench for instruction_decode_queue against a queue-based
// reference model; honours INSTR_DECODE_HAZARD_EN for the interlock expectations.
module tb_instruction_decode_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
`ifdef INSTR_DECODE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc, out_pc;
    logic [5:0]  Op;
    logic [4:0]  Rs, Rt, Rd;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [2:0]  alu_src;
    logic        alu_control, jump, jumpLink, jumpReg, branchE, branchNE;
    logic        mem_write, reg_write, regDst, memToReg, illegal, hazard_stall;
    logic [2:0]  count;

    always #5 clk = ~clk;

    instruction_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .imm(imm), .addr(addr), .alu_src(alu_src), .alu_control(alu_control),
        .jump(jump), .jumpLink(jumpLink), .jumpReg(jumpReg), .branchE(branchE),
        .branchNE(branchNE), .mem_write(mem_write), .reg_write(reg_write),
        .regDst(regDst), .memToReg(memToReg), .illegal(illegal),
        .hazard_stall(hazard_stall), .count(count)
    );

    logic [13:0] dut_ctrl;
    logic [62:0] dut_fields;
    assign dut_ctrl   = {illegal, jump, jumpLink, jumpReg, branchE, branchNE, mem_write,
                         reg_write, regDst, memToReg, alu_control, alu_src};
    assign dut_fields = {Op, Rs, Rt, Rd, imm, addr};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected control vector straight from the decode table, same packing as dut_ctrl.
    function automatic logic [13:0] exp_ctrl(input logic [31:0] w);
        logic ill, j, jl, jr, be, bn, mw, rw, rd, m2r, ac;
        logic [2:0] as;
        {ill, j, jl, jr, be, bn, mw, rw, rd, m2r, ac} = 11'd0;
        as = 3'd0;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20: begin rw = 1; rd = 1; as = 3'd0; end
                6'h22: begin rw = 1; rd = 1; as = 3'd1; end
                6'h26: begin rw = 1; rd = 1; as = 3'd2; end
                6'h2A: begin rw = 1; rd = 1; as = 3'd3; end
                6'h08: jr = 1;
                default: ill = 1;
            endcase
            6'h02: j = 1;
            6'h03: begin j = 1; jl = 1; rw = 1; end
            6'h04: begin be = 1; as = 3'd1; end
            6'h05: begin bn = 1; as = 3'd1; end
            6'h08: begin rw = 1; ac = 1; as = 3'd0; end
            6'h0E: begin rw = 1; ac = 1; as = 3'd2; end
            6'h23: begin rw = 1; m2r = 1; ac = 1; end
            6'h2B: begin mw = 1; ac = 1; end
            default: ill = 1;
        endcase
        return {ill, j, jl, jr, be, bn, mw, rw, rd, m2r, ac, as};
    endfunction

    function automatic bit uses_reg(input logic [31:0] w, input logic [4:0] r);
        bit rs_rd, rt_rd;
        rs_rd = !(w[31:26] == 6'h02 || w[31:26] == 6'h03);
        rt_rd = (w[31:26] == 6'h00) || (w[31:26] == 6'h04) || (w[31:26] == 6'h05) ||
                (w[31:26] == 6'h2B);
        return (r != 5'd0) && ((rs_rd && w[25:21] == r) || (rt_rd && w[20:16] == r));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 11))
            0, 1: begin
                w[31:26] = 6'h00;
                case ($urandom_range(0, 4))
                    0: w[5:0] = 6'h20;
                    1: w[5:0] = 6'h22;
                    2: w[5:0] = 6'h26;
                    3: w[5:0] = 6'h2A;
                    default: w[5:0] = 6'h08;
                endcase
            end
            2:  w[31:26] = 6'h00;
            3:  w[31:26] = 6'h02;
            4:  w[31:26] = 6'h03;
            5:  w[31:26] = 6'h04;
            6:  w[31:26] = 6'h05;
            7:  w[31:26] = 6'h08;
            8:  w[31:26] = 6'h0E;
            9:  w[31:26] = 6'h23;
            10: w[31:26] = 6'h2B;
            default: w = w;
        endcase
        return w;
    endfunction

    // Reference model: queue of waiting words plus the word sitting in the output slot.
    logic [31:0] mq_i[$];
    logic [31:0] mq_p[$];
    bit          m_ov, m_rv, m_hs;
    logic [31:0] m_oi, m_op;
    logic [4:0]  m_rr;

    task automatic model_step();
        bit handoff, can_load, stall, pop, push, ev;
        logic [4:0] er;
        if (reset) begin
            mq_i.delete(); mq_p.delete();
            m_ov = 0; m_rv = 0; m_rr = 5'd0; m_hs = 0;
        end else if (flush) begin
            mq_i.delete(); mq_p.delete();
            m_ov = 0; m_rv = 0; m_hs = 0;
        end else begin
            handoff  = m_ov && out_ready;
            can_load = (mq_i.size() > 0) && (!m_ov || out_ready);
            ev = m_rv;
            er = m_rr;
            if (handoff) begin
                ev = (m_oi[31:26] == 6'h23) && (m_oi[20:16] != 5'd0);
                er = m_oi[20:16];
            end
            stall = HZ && can_load && ev && uses_reg(mq_i[0], er);
            pop   = can_load && !stall;
            push  = in_valid && (mq_i.size() < DEPTH);
            if (stall) m_rv = 0;
            else begin m_rv = ev; m_rr = er; end
            m_hs = stall;
            if (pop) begin
                m_oi = mq_i.pop_front();
                m_op = mq_p.pop_front();
                m_ov = 1;
            end else if (handoff) m_ov = 0;
            if (push) begin
                mq_i.push_back(in_instr);
                mq_p.push_back(in_pc);
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("in_ready", in_ready, !reset && (mq_i.size() < DEPTH));
        check_eq("count", count, mq_i.size());
        check_eq("out_valid", out_valid, m_ov);
        check_eq("hazard_stall", hazard_stall, m_hs);
        if (m_ov) begin
            check_eq("out_pc", out_pc, m_op);
            check_eq("fields", dut_fields, {m_oi[31:26], m_oi[25:21], m_oi[20:16],
                                            m_oi[15:11], m_oi[15:0], m_oi[25:0]});
            check_eq("ctrl", dut_ctrl, exp_ctrl(m_oi));
        end
    endtask

    task automatic drive(input bit rst, input bit fl, input bit iv, input logic [31:0] ins,
                         input logic [31:0] pc, input bit ordy);
        reset = rst; flush = fl; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    bit r_b, f_b;

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check_eq("rst_in_ready", in_ready, 0);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("rel_in_ready", in_ready, 1);

        // jal: visible two cycles after the push
        drive(0, 0, 1, 32'h0C000007, 32'h100, 1);
        check_eq("jal_lat_valid", out_valid, 0);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("jal_valid", out_valid, 1);
        check_eq("jal_op", Op, 6'b000011);
        check_eq("jal_addr", addr, 26'h0000007);
        check_eq("jal_ctrl", {jump, jumpLink, reg_write, illegal}, 4'b1110);

        // addi
        drive(0, 0, 1, 32'h2041E000, 32'h104, 1);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("addi_regs", {Rs, Rt}, {5'd2, 5'd1});
        check_eq("addi_imm", imm, 16'hE000);
        check_eq("addi_ctrl", {reg_write, alu_control, regDst}, 3'b110);

        // saturate with out_ready low, then drain in order
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++)
            drive(0, 0, 1, {6'h08, 5'd1, 5'd2, 16'(k)}, 32'h200 + 32'(4 * k), 0);
        check_eq("full_count", count, 4);
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_hold_pc", out_pc, 32'h200);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 0, 0, 1);
            check_eq("drain_pc", out_pc, 32'h200 + 32'(4 * k));
        end
        drive(0, 0, 0, 0, 0, 1);
        check_eq("drained_valid", out_valid, 0);

        // flush with a push offered in the same cycle
        for (int k = 0; k < 4; k++)
            drive(0, 0, 1, 32'h00221820, 32'h280 + 32'(4 * k), 0);
        check_eq("pre_flush_count", count, 3);
        drive(0, 1, 1, 32'h2041E000, 32'h2F0, 0);
        check_eq("flush_count", count, 0);
        check_eq("flush_valid", out_valid, 0);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("flush_drop_valid", out_valid, 0);

        // load-use: lw r1 then add r3,r1,r2
        drive(0, 0, 1, 32'h8C410000, 32'h300, 1);
        drive(0, 0, 1, 32'h00221820, 32'h304, 1);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("hz_stall", hazard_stall, HZ);
        check_eq("hz_bubble_valid", out_valid, !HZ);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("hz_after_valid", out_valid, HZ);
        check_eq("hz_after_pc", out_pc, 32'h304);

        // illegal opcode
        drive(0, 0, 1, 32'hFC000000, 32'h400, 1);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("ill_valid", out_valid, 1);
        check_eq("ill_ctrl", dut_ctrl, 14'h2000);

        // reset mid-stream
        drive(0, 0, 1, 32'h00221820, 32'h500, 0);
        drive(0, 0, 1, 32'h8C410000, 32'h504, 0);
        drive(1, 0, 1, 32'h2041E000, 32'h508, 0);
        check_eq("mrst_zero", {out_valid, in_ready, hazard_stall, count, out_pc, dut_ctrl}, 0);
        check_eq("mrst_fields", dut_fields, 0);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("mrst_rel_ready", in_ready, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r_b = ($urandom_range(0, 199) == 0);
            f_b = ($urandom_range(0, 31) == 0);
            drive(r_b, f_b, $urandom_range(0, 9) < 7, rand_instr(), $urandom,
                  $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_decode_queue.md
# instruction_decode_queue

Buffered, pipelined MIPS instruction decoder between fetch and register read. A parametrised FIFO of DEPTH fetched instructions feeds a registered decode stage with valid/ready handshakes on both sides. The block also supports pipeline flush and an optional load-use interlock. Decoded field and control names match the single-cycle decoder they replace.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- PC_W, 32, width of the PC carried with each instruction
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept; high when count < DEPTH
- in_instr  in  32  instruction word
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  discard all queued and decoded instructions
- out_valid  out  1  decoded instruction present
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  PC of the decoded instruction
- Op  out  6; Rs, Rt, Rd  out  5 each; imm  out  16; addr  out  26  raw fields [31:26], [25:21], [20:16], [15:11], [15:0], [25:0]
- alu_src  out  3  ALU operation: 000 add, 001 sub, 010 xor, 011 slt
- alu_control  out  1  ALU B operand is imm (sign-extended downstream)
- jump, jumpLink, jumpReg, branchE, branchNE, mem_write, reg_write, regDst, memToReg  out  1 each  decoded controls
- illegal  out  1  unsupported opcode or funct; all controls 0
- hazard_stall  out  1  load-use bubble in progress
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Push: in_valid && in_ready && !flush writes {in_instr, in_pc} at the write pointer. Pointers wrap modulo DEPTH.
- Pop: when the FIFO is non-empty and the output register is empty or handing off (out_valid && out_ready), the head entry is decoded and loaded into the output register.
- A full FIFO never accepts, even on a same-cycle pop. There is no pass-through.
- Simultaneous push and pop leaves count unchanged.
- Output fields hold while out_valid && !out_ready.
- Decode table:
  - Op 000000, funct 100000/100010/100110/101010: reg_write=1, regDst=1, alu_src 000/001/010/011.
  - Op 000000, funct 001000 (jr): jumpReg=1.
  - Op 000010 (j): jump=1.
  - Op 000011 (jal): jump=1, jumpLink=1, reg_write=1. Downstream writes r31.
  - Op 000100 (beq): branchE=1, alu_src=001. Op 000101 (bne): branchNE=1, alu_src=001.
  - Op 001000 (addi): reg_write=1, alu_control=1, alu_src=000. Op 001110 (xori): same with alu_src=010.
  - Op 100011 (lw): reg_write=1, memToReg=1, alu_control=1. Op 101011 (sw): mem_write=1, alu_control=1.
  - Anything else: illegal=1, all controls 0, fields still decoded.
- Flush has priority over push and pop. The next cycle has count=0, out_valid=0, and pointers equal. in_valid is ignored during flush.

## Timing
- Reset: all outputs 0, except in_ready=1 on the first cycle after reset is released. in_ready is 0 while reset is asserted.
- Reset mid-operation drops every queued entry. There is no partial drain.
- Latency: a push on cycle N reaches out_valid at cycle N+2 when the queue is empty.
- Throughput: one instruction per cycle with out_ready held high.
- count updates on the clock edge after a push or pop.

## Configuration
- INSTR_DECODE_HAZARD_EN defined:
  - The block records the last handed-off instruction's Rt if that instruction was lw.
  - If the next head instruction reads that register, one bubble cycle is inserted: out_valid=0, hazard_stall=1, head not popped.
  - Reads are Rs for all non-jump ops, plus Rt for R-type, beq, bne and sw.
  - r0 never hazards. Flush or reset clears the record.
- INSTR_DECODE_HAZARD_EN undefined: no bubble, hazard_stall tied 0.

## Structure
- Package instr_decode_pkg holds opcode, funct and alu_src constants, plus a decoded-instruction struct containing the fields and controls.
- Sub-module instr_decode_comb is purely combinational: 32-bit word in, struct out. The top holds the FIFO, output register and hazard logic.

## Test plan
- Reset then push 0x0C000007 (jal) -> after 2 cycles: out_valid=1, Op=000011, addr=0x0000007, jump=1, jumpLink=1, reg_write=1, illegal=0.
- Push 0x2041E000 (addi) -> Rs=2, Rt=1, imm=0xE000, reg_write=1, alu_control=1, regDst=0.
- Hold out_ready=0 and push 5 words with DEPTH=4 -> count saturates at 4 with in_ready=0; output holds the first word; then out_ready=1 drains in order, one per cycle.
- Fill to 3 entries, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, pushed word dropped.
- With the macro: lw r1 (0x8C410000) then add r3,r1,r2 -> one cycle with hazard_stall=1 and out_valid=0, then add issues. Without the macro: back-to-back issue.
- Push 0xFC000000 -> illegal=1, all controls 0. Assert reset mid-stream -> all outputs 0 next cycle.
